// File: rtl/djb2_pkg.sv
// Shared constants, state type and byte-select helper for the djb2 byte feeder.
package djb2_pkg;

  localparam int BYTES_PER_WORD = 4;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

  // Byte idx of a word in emission order. MSB-first walks down from bits [31:24].
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input int          order);
    logic [7:0] b;
    case (order)
      MSB_FIRST: b = word[8*(3-idx) +: 8];
      LSB_FIRST: b = word[8*idx +: 8];
      default:   b = word[8*idx +: 8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/djb2_len_counter.sv
// Saturating message-length counter with sticky overflow flag.
module djb2_len_counter #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [LEN_W-1:0] count,
  output logic             at_max,
  output logic             ovf
);

  logic [LEN_W-1:0] r_count;
  logic             r_ovf;

  assign at_max = &r_count;
  assign count  = r_count;
  assign ovf    = r_ovf;

  // Count handshaken bytes; an increment at full scale only sets the overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (inc) begin
      if (at_max) r_ovf   <= 1'b1;
      else        r_count <= r_count + LEN_W'(1);
    end
  end

endmodule

// File: rtl/djb2_byte_feeder.sv
// Serialises 32-bit message words into one byte per cycle for the djb2 hash core,
// tagging first/last bytes and reporting the message length at end of message.
//
// state | meaning
// IDLE  | no word held, ready for the next word
// SHIFT | emitting bytes of the held word
module djb2_byte_feeder
  import djb2_pkg::*;
#(
  parameter int BYTE_ORDER = LSB_FIRST,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic [1:0]       s_nbytes,
  output logic             s_ready,
  output logic [7:0]       m_byte,
  output logic             m_valid,
  output logic             m_first,
  output logic             m_last,
  input  logic             m_ready,
  output logic [LEN_W-1:0] msg_len,
  output logic             len_valid,
  output logic             len_ovf
);

  localparam logic [1:0] FULL_LAST_IDX = 2'(BYTES_PER_WORD - 1);

  feeder_state_t    r_state;
  logic [31:0]      r_word;
  logic             r_last;
  logic [1:0]       r_last_idx;
  logic [1:0]       r_idx;
  logic             r_first_pend;
  logic [LEN_W-1:0] r_msg_len;
  logic             r_len_valid;
  logic             r_len_ovf;

  logic             w_busy;
  logic             w_word_done;
  logic             w_hs;
  logic             w_hs_last;
  logic             w_load;
  logic [LEN_W-1:0] w_count;
  logic             w_cnt_max;
  logic             w_ovf;

  assign w_busy      = (r_state == SHIFT);
  assign w_word_done = w_busy && (r_idx == r_last_idx);
  assign w_hs        = w_busy && m_ready;
  assign w_hs_last   = w_hs && w_word_done && r_last;

  // Combinational from m_ready so the next word loads in the cycle the last byte leaves.
  assign s_ready = !w_busy || (m_ready && w_word_done);
  assign w_load  = s_valid && s_ready;

  assign m_valid   = w_busy;
  assign m_byte    = w_busy ? pick_byte(r_word, r_idx, BYTE_ORDER) : 8'h00;
  assign m_first   = w_busy && r_first_pend;
  assign m_last    = w_word_done && r_last;
  assign msg_len   = r_msg_len;
  assign len_valid = r_len_valid;
  assign len_ovf   = r_len_ovf;

  // Word capture, byte index stepping and first-byte tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_last       <= 1'b0;
      r_last_idx   <= FULL_LAST_IDX;
      r_idx        <= '0;
      r_first_pend <= 1'b1;
    end else begin
      if (w_hs) r_first_pend <= w_hs_last;
      if (w_load) begin
        r_state    <= SHIFT;
        r_word     <= s_data;
        r_last     <= s_last;
        // nbytes=0 wraps to index 3, i.e. a full word; non-last words are always full.
        r_last_idx <= s_last ? (s_nbytes - 2'd1) : FULL_LAST_IDX;
        r_idx      <= '0;
      end else if (w_hs) begin
        if (w_word_done) r_state <= IDLE;
        else             r_idx   <= r_idx + 2'd1;
      end
    end
  end

  djb2_len_counter #(.LEN_W(LEN_W)) u_len_counter (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_hs),
    .clr    (w_hs_last),
    .count  (w_count),
    .at_max (w_cnt_max),
    .ovf    (w_ovf)
  );

  // Publish the final length (including the last byte) with a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msg_len   <= '0;
      r_len_valid <= 1'b0;
      r_len_ovf   <= 1'b0;
    end else begin
      r_len_valid <= w_hs_last;
      if (w_hs_last) begin
        r_msg_len <= w_cnt_max ? w_count : (w_count + LEN_W'(1));
        r_len_ovf <= w_ovf | w_cnt_max;
      end
    end
  end

endmodule

// File: tb/tb_djb2_byte_feeder.sv
// Scoreboard bench: three feeders (LSB/16, MSB/16, LSB/3) share one stimulus stream.
module tb_djb2_byte_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [1:0]  s_nbytes = '0;
  logic        m_ready = 1'b1;

  logic [7:0]  mb [3];
  logic        mv [3];
  logic        mf [3];
  logic        ml [3];
  logic        lv [3];
  logic        lo [3];
  logic        sr [3];
  logic [15:0] mlen0, mlen1;
  logic [2:0]  mlen2;

  always #5 clk = ~clk;

  djb2_byte_feeder #(.BYTE_ORDER(0), .LEN_W(16)) u_lsb (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_nbytes(s_nbytes), .s_ready(sr[0]), .m_byte(mb[0]), .m_valid(mv[0]),
    .m_first(mf[0]), .m_last(ml[0]), .m_ready(m_ready), .msg_len(mlen0),
    .len_valid(lv[0]), .len_ovf(lo[0]));

  djb2_byte_feeder #(.BYTE_ORDER(1), .LEN_W(16)) u_msb (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_nbytes(s_nbytes), .s_ready(sr[1]), .m_byte(mb[1]), .m_valid(mv[1]),
    .m_first(mf[1]), .m_last(ml[1]), .m_ready(m_ready), .msg_len(mlen1),
    .len_valid(lv[1]), .len_ovf(lo[1]));

  djb2_byte_feeder #(.BYTE_ORDER(0), .LEN_W(3)) u_sat (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_nbytes(s_nbytes), .s_ready(sr[2]), .m_byte(mb[2]), .m_valid(mv[2]),
    .m_first(mf[2]), .m_last(ml[2]), .m_ready(m_ready), .msg_len(mlen2),
    .len_valid(lv[2]), .len_ovf(lo[2]));

  typedef struct { logic [7:0] b; logic f; logic l; } exp_b_t;
  typedef struct { int len; logic ovf; } exp_l_t;

  exp_b_t      qb [3][$];
  exp_l_t      ql [3][$];
  logic [31:0] wq [$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_first = 0;
  int t_last = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] len_of(input int d);
    case (d)
      0:       return mlen0;
      1:       return mlen1;
      default: return {13'd0, mlen2};
    endcase
  endfunction

  function automatic int pending();
    int n = 0;
    for (int d = 0; d < 3; d++) n += qb[d].size() + ql[d].size();
    return n;
  endfunction

  // m_ready shaping: 0 = always ready, 1 = random, 2 = pattern 1,0,0
  initial begin
    int k = 0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       m_ready = ($urandom_range(0, 3) != 0);
        2:       m_ready = (k % 3 == 0);
        default: m_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Monitor: samples 1 time unit before each rising edge
  initial begin
    logic       pv [3];
    logic       pf [3];
    logic       pl [3];
    logic [7:0] pb [3];
    logic       prdy;
    logic       prst;
    exp_b_t     eb;
    exp_l_t     el;
    prdy = 1'b1;
    prst = 1'b0;
    for (int d = 0; d < 3; d++) begin pv[d] = 0; pf[d] = 0; pl[d] = 0; pb[d] = 0; end
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          if (mv[d] && m_ready) begin
            if (qb[d].size() == 0) chk($sformatf("unexpected_byte_d%0d", d), {mb[d], mf[d], ml[d]}, 32'hFFFF_FFFF);
            else begin
              eb = qb[d].pop_front();
              chk($sformatf("byte_d%0d", d), {mb[d], mf[d], ml[d]}, {eb.b, eb.f, eb.l});
            end
            if (d == 0 && mf[d]) t_first = cyc;
            if (d == 0 && ml[d]) t_last = cyc;
          end
          if (lv[d]) begin
            if (ql[d].size() == 0) chk($sformatf("unexpected_len_valid_d%0d", d), len_of(d), 32'hFFFF_FFFF);
            else begin
              el = ql[d].pop_front();
              chk($sformatf("msg_len_d%0d", d), {lo[d], len_of(d)}, {el.ovf, el.len[15:0]});
            end
          end
          if (mv[d] && !m_ready) chk($sformatf("s_ready_stall_d%0d", d), sr[d], 0);
          if (prst && pv[d] && !prdy)
            chk($sformatf("stall_hold_d%0d", d), {mv[d], mf[d], ml[d], mb[d]}, {1'b1, pf[d], pl[d], pb[d]});
        end
        pv[d] = mv[d]; pf[d] = mf[d]; pl[d] = ml[d]; pb[d] = mb[d];
      end
      prdy = m_ready;
      prst = rst;
    end
  end

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic drive_word(input logic [31:0] d, input logic l, input logic [1:0] n);
    int tries = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l; s_nbytes = n;
    #1;
    while (!sr[0]) begin
      tries++;
      if (tries > 1000) begin
        n_fail++;
        $display("FAIL s_ready_timeout: got 0, expected 1");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "stalled");
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
  endtask

  // Reference model: bytes per word in emission order, length from the byte total.
  task automatic send_msg(input logic [1:0] nb, input int gap);
    int     total = 0;
    int     last_i = wq.size() - 1;
    int     n;
    exp_b_t e;
    exp_l_t el;
    for (int i = 0; i <= last_i; i++) begin
      n = (i == last_i) ? ((nb == 0) ? 4 : int'(nb)) : 4;
      for (int k = 0; k < n; k++) begin
        e.f = (total == 0);
        e.l = (i == last_i) && (k == n - 1);
        e.b = 8'(wq[i] >> (8 * k));
        qb[0].push_back(e);
        qb[2].push_back(e);
        e.b = 8'(wq[i] >> (8 * (3 - k)));
        qb[1].push_back(e);
        total++;
      end
    end
    el.len = (total > 65535) ? 65535 : total; el.ovf = (total > 65535);
    ql[0].push_back(el); ql[1].push_back(el);
    el.len = (total > 7) ? 7 : total; el.ovf = (total > 7);
    ql[2].push_back(el);
    for (int i = 0; i <= last_i; i++)
      drive_word(wq[i], i == last_i, (i == last_i) ? nb : 2'($urandom));
    if (gap > 0) begin
      @(negedge clk);
      s_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    int c = 0;
    @(negedge clk);
    s_valid = 1'b0;
    while (pending() != 0 && c < 500) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    chk(name, pending(), 0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_b_t e;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", {mv[d], mf[d], ml[d], mb[d]}, 0);
      chk("reset_ready_len", {sr[d], lv[d], lo[d], len_of(d)}, {1'b1, 18'd0});
    end
    @(negedge clk);
    rst = 1'b1;

    // single word "abcd"
    rdy_mode = 0;
    wq.delete(); wq.push_back(32'h6463_6261);
    send_msg(2'd0, 2);
    drain("drain_abcd");
    chk("abcd_span", t_last - t_first, 3);

    // partial last word, s_valid held between words
    wq.delete(); wq.push_back(32'h6463_6261); wq.push_back(32'h0067_6665);
    send_msg(2'd3, 2);
    drain("drain_partial");
    chk("no_bubble_span", t_last - t_first, 6);

    // back-pressure 1,0,0 pattern
    rdy_mode = 2;
    wq.delete(); wq.push_back(32'h6463_6261);
    send_msg(2'd0, 0);
    wq.delete(); wq.push_back(32'h6463_6261); wq.push_back(32'h0067_6665);
    send_msg(2'd3, 1);
    drain("drain_backpressure");

    // MSB-first word and single-byte messages
    rdy_mode = 0;
    wq.delete(); wq.push_back(32'h6162_6364);
    send_msg(2'd0, 1);
    wq.delete(); wq.push_back(32'h61A5_A5A5);
    send_msg(2'd1, 1);
    drain("drain_msb");

    // 12-byte message saturates the 3-bit counter, then a 1-byte message
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(32'h1111_1111 * (i + 1));
    send_msg(2'd0, 1);
    wq.delete(); wq.push_back(32'h0000_00AB);
    send_msg(2'd1, 1);
    drain("drain_overflow");

    // reset after 2 of 4 bytes
    for (int d = 0; d < 3; d++) begin
      e.f = 1'b1; e.l = 1'b0;
      e.b = (d == 1) ? 8'h64 : 8'h61;
      qb[d].push_back(e);
      e.f = 1'b0;
      e.b = (d == 1) ? 8'h63 : 8'h62;
      qb[d].push_back(e);
    end
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'h6463_6261; s_last = 1'b1; s_nbytes = 2'd0;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("midreset_valid", {mv[d], mf[d], ml[d], mb[d]}, 0);
      chk("midreset_ready_len", {sr[d], lv[d], lo[d], len_of(d)}, {1'b1, 18'd0});
    end
    chk("midreset_bytes_seen", pending(), 0);
    for (int d = 0; d < 3; d++) begin qb[d].delete(); ql[d].delete(); end
    @(negedge clk);
    rst = 1'b1;
    wq.delete(); wq.push_back(32'h0000_7978);
    send_msg(2'd2, 1);
    drain("drain_after_reset");

    // randomized messages under mixed back-pressure
    for (int m = 0; m < 30; m++) begin
      rdy_mode = $urandom_range(0, 2);
      wq.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) wq.push_back($urandom);
      send_msg(2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end
    drain("drain_random");

    finish_run();
  end

endmodule

// File: doc/djb2_byte_feeder.md
Name: djb2_byte_feeder

Overview:
- Upstream stage of the djb2 hash core.
- Accepts 32-bit message words over a valid/ready stream and serialises them into one byte per cycle.
- Marks message first/last bytes so the hash core knows when to seed and when to finalise.
- Counts message length in bytes and reports it with a one-cycle strobe at end of message.

Parameters:
- BYTE_ORDER, 0, byte emission order: 0 = LSB first (bits [7:0] first), 1 = MSB first.
- LEN_W, 16, width of the message byte counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- s_data  in  32  message word.
- s_valid  in  1  s_data/s_last/s_nbytes valid.
- s_last  in  1  word is the final word of the message.
- s_nbytes  in  2  valid bytes in the last word: 0 = 4, 1..3 = that many; ignored when s_last=0.
- s_ready  out  1  feeder accepts a word this cycle.
- m_byte  out  8  byte to the hash core.
- m_valid  out  1  m_byte valid.
- m_first  out  1  m_byte is the first byte of a message.
- m_last  out  1  m_byte is the last byte of a message.
- m_ready  in  1  hash core accepts m_byte.
- msg_len  out  LEN_W  byte count of the most recently completed message.
- len_valid  out  1  one-cycle strobe: msg_len updated.
- len_ovf  out  1  message exceeded 2^LEN_W-1 bytes; msg_len saturated.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. s_ready=1. m_valid=0, m_first=0, m_last=0, m_byte=0. msg_len=0, len_valid=0, len_ovf=0. Byte index=0, internal count=0, first-pending flag=1.
- FSM states:
  - IDLE: no word held; s_ready=1. On s_valid, capture word, s_last and effective nbytes (0 maps to 4), go to SHIFT with byte index 0.
  - SHIFT: m_valid=1; m_byte = byte[idx] in BYTE_ORDER. On m_valid&&m_ready, idx increments.
  - When the final byte of the held word is handshaken:
    - If s_valid is also present, load the next word in the same cycle and stay in SHIFT with idx=0 (no bubble).
    - Otherwise go to IDLE.
- s_ready = IDLE || (SHIFT && m_ready && idx==nbytes-1). It is combinational from m_ready (documented comb path).
- m_first = first-pending && m_valid. first-pending is set at reset and after each m_last handshake, and cleared on any byte handshake.
- m_last = held s_last && idx==nbytes-1.
- m_byte, m_first and m_last are held stable while m_valid && !m_ready.
- Byte counter:
  - Increments on every m handshake and saturates at 2^LEN_W-1.
  - Sets the internal ovf flag if an increment is attempted at max.
  - On the m_last handshake: msg_len <= final count (including that byte, saturated), len_ovf <= ovf, len_valid <= 1 for exactly one cycle. Counter and ovf then clear for the next message.
- len_ovf holds its value until the next len_valid.
- A message with s_nbytes=1 on a single word gives m_first and m_last on the same byte; msg_len=1.
- Non-last words always emit 4 bytes regardless of s_nbytes.
- Reset mid-message drops the held word and the partial count; no len_valid is issued.

Decomposition:
- Package djb2_pkg holds:
  - BYTES_PER_WORD=4.
  - The state enum {IDLE, SHIFT}.
  - BYTE_ORDER constants LSB_FIRST=0 and MSB_FIRST=1.
- Sub-module djb2_len_counter: saturating LEN_W counter with inc, clr and ovf outputs, instantiated once.

Test Plan:
- Single word "abcd": s_data=0x64636261, s_last=1, s_nbytes=0, m_ready=1 -> bytes 0x61,0x62,0x63,0x64 on 4 consecutive cycles. m_first on 0x61, m_last on 0x64. len_valid the next cycle with msg_len=4, len_ovf=0.
- Partial last word: words 0x64636261 then 0x00676665 with s_last=1, s_nbytes=3 -> 7 bytes 0x61..0x67, m_last on 0x67, msg_len=7. No bubble between 0x64 and 0x65 when s_valid is held.
- Back-pressure: m_ready toggles 1,0,0,1,... -> m_byte and flags stay stable while stalled; s_ready=0 until the last byte is accepted; byte sequence is unchanged.
- MSB-first (BYTE_ORDER=1): 0x61626364, s_last=1 -> 0x61,0x62,0x63,0x64; single byte with s_nbytes=1 -> m_first=m_last=1, msg_len=1.
- Overflow (LEN_W=3): 3 full words, last flagged -> msg_len=7, len_ovf=1. The next 1-byte message -> msg_len=1, len_ovf=0.
- Reset mid-message: rst=0 after 2 of 4 bytes -> all outputs return to reset values immediately. The next message starts with m_first=1, and msg_len counts only the new message.
